// File: rtl/fetch_buffer_if.sv
// Handshake bundle between instruction memory, the fetch buffer and the two decoder slots.
// The slave modport is the buffer side and the master modport is the memory/decoder side.
interface fetch_buffer_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
);
    logic                    flush_i;
    logic                    mem_valid_i;
    logic [63:0]             mem_data_i;
    logic [XLEN-1:0]         mem_pc_i;
    logic                    fetch_ready_o;
    logic [1:0]              dec_take_i;
    logic [31:0]             inst0_o;
    logic [XLEN-1:0]         pc0_o;
    logic                    fetched0_o;
    logic [31:0]             inst1_o;
    logic [XLEN-1:0]         pc1_o;
    logic                    fetched1_o;
    logic [$clog2(DEPTH):0]  count_o;

    modport slave (
        input  flush_i, mem_valid_i, mem_data_i, mem_pc_i, dec_take_i,
        output fetch_ready_o, inst0_o, pc0_o, fetched0_o, inst1_o, pc1_o, fetched1_o, count_o
    );

    modport master (
        output flush_i, mem_valid_i, mem_data_i, mem_pc_i, dec_take_i,
        input  fetch_ready_o, inst0_o, pc0_o, fetched0_o, inst1_o, pc1_o, fetched1_o, count_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Dual-issue instruction fetch queue: circular FIFO of {inst, pc} feeding two decoder slots.
// Optional macro FETCH_BUFFER_BYPASS_EN presents a packet pushed into an empty queue in the same cycle.
module fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SPACE_LIMIT = CW'(DEPTH - 2);

    logic [31:0]     r_inst [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_ready;
    logic            w_push;
    logic            w_bypass;
    logic [1:0]      w_push_n;
    logic [1:0]      w_avail;
    logic [1:0]      w_pop_n;
    logic [XLEN-1:0] w_base_pc;
    logic [31:0]     w_e0_inst;
    logic [31:0]     w_e1_inst;
    logic [XLEN-1:0] w_e0_pc;
    logic [XLEN-1:0] w_e1_pc;
    logic [AW-1:0]   w_head_p1;
    logic [AW-1:0]   w_tail_p1;
    logic [CW-1:0]   w_count_nxt;
    logic [31:0]     w_inst0;
    logic [31:0]     w_inst1;
    logic [XLEN-1:0] w_pc0;
    logic [XLEN-1:0] w_pc1;
    logic            w_fetched0;
    logic            w_fetched1;
    logic            w_unused;

    assign w_unused  = ^bus.mem_pc_i[1:0];
    assign w_base_pc = {bus.mem_pc_i[XLEN-1:2], 2'b00};
    assign w_head_p1 = r_head + AW'(1);
    assign w_tail_p1 = r_tail + AW'(1);

    // Space check uses only the registered count, so same-cycle pops never make room.
    assign w_ready = (r_count <= SPACE_LIMIT);
    assign w_push  = bus.mem_valid_i & w_ready & ~bus.flush_i;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass = w_push & (r_count == {CW{1'b0}});
`else
    assign w_bypass = 1'b0;
`endif

    // Split the fetch packet into the entries it contributes; a target in the upper word yields one.
    always_comb begin
        w_e0_inst = bus.mem_data_i[31:0];
        w_e0_pc   = w_base_pc;
        w_e1_inst = bus.mem_data_i[63:32];
        w_e1_pc   = w_base_pc + XLEN'(4);
        w_push_n  = 2'd0;
        case (bus.mem_pc_i[2])
            1'b0: begin
                w_e0_inst = bus.mem_data_i[31:0];
                w_e0_pc   = w_base_pc;
                w_e1_inst = bus.mem_data_i[63:32];
                w_e1_pc   = w_base_pc + XLEN'(4);
                w_push_n  = 2'd2;
            end
            1'b1: begin
                w_e0_inst = bus.mem_data_i[63:32];
                w_e0_pc   = w_base_pc;
                w_e1_inst = 32'h0000_0000;
                w_e1_pc   = w_base_pc;
                w_push_n  = 2'd1;
            end
            default: begin
                w_push_n  = 2'd0;
            end
        endcase
    end

    // Presentation to the decoder slots, either from the head entries or straight from the packet.
    always_comb begin
        w_inst0    = r_inst[r_head];
        w_pc0      = r_pc[r_head];
        w_inst1    = r_inst[w_head_p1];
        w_pc1      = r_pc[w_head_p1];
        w_fetched0 = 1'b0;
        w_fetched1 = 1'b0;
        if (w_bypass) begin
            w_inst0    = w_e0_inst;
            w_pc0      = w_e0_pc;
            w_inst1    = w_e1_inst;
            w_pc1      = w_e1_pc;
            w_fetched0 = 1'b1;
            w_fetched1 = (w_push_n == 2'd2);
        end else begin
            w_fetched0 = (r_count >= CW'(1));
            w_fetched1 = (r_count >= CW'(2));
        end
    end

    // Decoder take is clamped to what is actually presented this cycle.
    always_comb begin
        w_avail = {1'b0, w_fetched0} + {1'b0, w_fetched1};
        w_pop_n = 2'd0;
        if (bus.dec_take_i > w_avail) begin
            w_pop_n = w_avail;
        end else begin
            w_pop_n = bus.dec_take_i;
        end
        if (w_push) begin
            w_count_nxt = r_count + CW'(w_push_n) - CW'(w_pop_n);
        end else begin
            w_count_nxt = r_count - CW'(w_pop_n);
        end
    end

    assign bus.inst0_o       = w_inst0;
    assign bus.pc0_o         = w_pc0;
    assign bus.fetched0_o    = w_fetched0;
    assign bus.inst1_o       = w_inst1;
    assign bus.pc1_o         = w_pc1;
    assign bus.fetched1_o    = w_fetched1;
    assign bus.count_o       = r_count;
    assign bus.fetch_ready_o = w_ready;

    // Pointer and occupancy state; flush outranks any same-cycle push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (bus.flush_i) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_count <= w_count_nxt;
            if (w_push) begin
                r_tail <= r_tail + AW'(w_push_n);
            end else begin
                r_tail <= r_tail;
            end
        end
    end

    // Entry storage; bypassed entries are still written but the head already skips them.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_inst[r_tail] <= w_e0_inst;
            r_pc[r_tail]   <= w_e0_pc;
            if (w_push_n == 2'd2) begin
                r_inst[w_tail_p1] <= w_e1_inst;
                r_pc[w_tail_p1]   <= w_e1_pc;
            end
        end
    end
endmodule
